// File: rtl/ram16k_bist_if.sv
// RAM-side bus between the BIST initiator (master) and the 16K x 16 RAM (slave).
// mem_out is a combinational read of mem_address within the same cycle.
interface ram16k_bist_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 16
);
  logic              mem_load;
  logic [DATA_W-1:0] mem_in;
  logic [ADDR_W-1:0] mem_address;
  logic [DATA_W-1:0] mem_out;

  modport master (output mem_load, output mem_in, output mem_address, input mem_out);
  modport slave  (input mem_load, input mem_in, input mem_address, output mem_out);
endinterface

// File: rtl/ram16k_bist.sv
// Four-pass RAM BIST (write P, check P, write ~P, check ~P); one address per cycle, busy for 4*DEPTH cycles.
// Optional BIST_STOP_ON_FAIL_EN: the first read mismatch ends the run in DONE immediately.
module ram16k_bist #(
  parameter int               ADDR_W = 14,
  parameter int               DATA_W = 16,
  parameter int               DEPTH  = 16384,
  parameter logic [DATA_W-1:0] SEED  = 16'hA5C3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  ram16k_bist_if.master      mem,
  output logic               busy,
  output logic               done,
  output logic               pass,
  output logic [15:0]        err_count,
  output logic [ADDR_W-1:0]  first_fail_addr,
  output logic [DATA_W-1:0]  first_fail_data
);

  typedef enum logic [2:0] {S_IDLE, S_W0, S_R0, S_W1, S_R1, S_DONE} state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] a;
  logic [DATA_W-1:0] pat, exp_dat;
  logic              walking, is_rd, last, mismatch, launch;

  assign walking  = (state == S_W0) || (state == S_R0) || (state == S_W1) || (state == S_R1);
  assign is_rd    = (state == S_R0) || (state == S_R1);
  assign last     = (a == LAST);
  assign pat      = SEED ^ DATA_W'(a);
  assign exp_dat  = (state == S_R1) ? ~pat : pat;
  // An aborting edge leaves the error registers exactly as they were.
  assign mismatch = is_rd && !abort && (mem.mem_out != exp_dat);
  assign launch   = ((state == S_IDLE) || (state == S_DONE)) && start;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_n = S_W0;
      S_W0:           if (last)  state_n = S_R0;
      S_R0:           if (last)  state_n = S_W1;
      S_W1:           if (last)  state_n = S_R1;
      S_R1:           if (last)  state_n = S_DONE;
      default:                   state_n = S_IDLE;
    endcase
`ifdef BIST_STOP_ON_FAIL_EN
    if (mismatch) state_n = S_DONE;
`endif
    if (walking && abort) state_n = S_IDLE;
  end

  always_comb begin
    mem.mem_load    = (state == S_W0) || (state == S_W1);
    mem.mem_address = walking ? a : '0;
    mem.mem_in      = (state == S_W0) ? pat : (state == S_W1) ? ~pat : '0;
    busy            = walking;
    done            = (state == S_DONE);
    pass            = (state == S_DONE) && (err_count == 16'd0);
  end

  // Every state change restarts the walk at address 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 a <= '0;
    else if (state_n != state)  a <= '0;
    else if (walking)           a <= a + 1'b1;
    else                        a <= '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_count       <= '0;
      first_fail_addr <= '0;
      first_fail_data <= '0;
    end else if (launch) begin
      err_count       <= '0;
      first_fail_addr <= '0;
      first_fail_data <= '0;
    end else if (mismatch) begin
      if (err_count != 16'hFFFF) err_count <= err_count + 16'd1;
      if (err_count == 16'd0) begin
        first_fail_addr <= a;
        first_fail_data <= mem.mem_out;
      end
    end
  end

endmodule

// File: tb/tb_ram16k_bist.sv
// Bench for ram16k_bist with DEPTH=16: behavioural RAM with injectable read faults, run-level scoreboard.
module tb_ram16k_bist;
  localparam int ADDR_W = 14;
  localparam int DATA_W = 16;
  localparam int DEPTH  = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic busy, done, pass;
  logic [15:0] err_count;
  logic [ADDR_W-1:0] first_fail_addr;
  logic [DATA_W-1:0] first_fail_data;

  ram16k_bist_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) mem_bus ();

  ram16k_bist #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .SEED(16'hA5C3)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .mem(mem_bus),
    .busy(busy), .done(done), .pass(pass), .err_count(err_count),
    .first_fail_addr(first_fail_addr), .first_fail_data(first_fail_data)
  );

  always #5 clk = ~clk;

  // Fault modes: 0 none, 1 bit0 stuck-at-0 at address 5, 2 read data forced to 0
  int fault = 0;
  logic [DATA_W-1:0] ram [DEPTH];
  logic [3:0] ridx;
  assign ridx = mem_bus.mem_address[3:0];

  always_ff @(posedge clk)
    if (mem_bus.mem_load) ram[ridx] <= mem_bus.mem_in;

  assign mem_bus.mem_out = (fault == 2) ? 16'h0000 :
                           (fault == 1 && mem_bus.mem_address == 14'd5) ? (ram[ridx] & 16'hFFFE) :
                           ram[ridx];

  typedef struct {
    int          cycles;
    int          errs;
    logic        pass;
    int          ffa;
    logic [15:0] ffd;
  } exp_t;
  exp_t sb[$];

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  task automatic chk_reset_vals(input string pfx);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_done"}, 32'(done), 0);
    chk({pfx, "_pass"}, 32'(pass), 0);
    chk({pfx, "_err_count"}, 32'(err_count), 0);
    chk({pfx, "_ffa"}, 32'(first_fail_addr), 0);
    chk({pfx, "_ffd"}, 32'(first_fail_data), 0);
    chk({pfx, "_mem_load"}, 32'(mem_bus.mem_load), 0);
    chk({pfx, "_mem_in"}, 32'(mem_bus.mem_in), 0);
    chk({pfx, "_mem_address"}, 32'(mem_bus.mem_address), 0);
  endtask

  // Push the expected outcome, launch a run, measure busy cycles, then pop and compare.
  task automatic run(input int f, input bit glitch);
    exp_t e;
    int cycles;
    fault = f;
    case (f)
`ifdef BIST_STOP_ON_FAIL_EN
      1: e = '{cycles: 3*DEPTH + 6, errs: 1, pass: 1'b0, ffa: 5, ffd: 16'h5A38};
      2: e = '{cycles: DEPTH + 1,   errs: 1, pass: 1'b0, ffa: 0, ffd: 16'h0000};
`else
      1: e = '{cycles: 4*DEPTH, errs: 1,  pass: 1'b0, ffa: 5, ffd: 16'h5A38};
      2: e = '{cycles: 4*DEPTH, errs: 32, pass: 1'b0, ffa: 0, ffd: 16'h0000};
`endif
      default: e = '{cycles: 4*DEPTH, errs: 0, pass: 1'b1, ffa: 0, ffd: 16'h0000};
    endcase
    sb.push_back(e);
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cycles = 0;
    while (busy && cycles < 2000) begin
      cycles++;
      start = glitch && (cycles == 30);
      @(negedge clk);
    end
    start = 1'b0;
    e = sb.pop_front();
    chk("busy_cycles", 32'(cycles), 32'(e.cycles));
    chk("done", 32'(done), 1);
    chk("pass", 32'(pass), 32'(e.pass));
    chk("err_count", 32'(err_count), 32'(e.errs));
    chk("first_fail_addr", 32'(first_fail_addr), 32'(e.ffa));
    chk("first_fail_data", 32'(first_fail_data), 32'(e.ffd));
  endtask

  initial begin
    int cycles;
    repeat (2) @(negedge clk);
    chk_reset_vals("rst");
    rst_n = 1'b1;

    run(0, 1'b0);
    chk("ram_addr5", 32'(ram[5]), 32'h5A39);
    chk("ram_addr0", 32'(ram[0]), 32'h5A3C);
    run(1, 1'b0);
    run(2, 1'b0);
    run(0, 1'b0);

    // Abort in R0 (cycle 20 of the run)
    fault = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    cycles = 1;
    while (cycles < 20 && busy) begin
      @(negedge clk);
      cycles++;
    end
    chk("abort_in_r0_busy", 32'(busy), 1);
    chk("abort_in_r0_load", 32'(mem_bus.mem_load), 0);
    abort = 1'b1;
    start = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    start = 1'b0;
    chk("abort_busy", 32'(busy), 0);
    chk("abort_done", 32'(done), 0);
    chk("abort_pass", 32'(pass), 0);
    chk("abort_mem_load", 32'(mem_bus.mem_load), 0);
    run(0, 1'b0);

    // Asynchronous reset between edges in W1
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    repeat (2*DEPTH + 3) @(negedge clk);
    chk("w1_mem_load", 32'(mem_bus.mem_load), 1);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("async_rst");
    @(negedge clk); rst_n = 1'b1;

    // start pulsed mid-run must not disturb the run
    run(0, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
